// File: rtl/vending_credit_ctrl.sv
// Vending credit controller: coin accumulation, price compare, vend/refund.
// Define VEND_CHANGE_EN to vend on credit >= price and refund the change.
module vending_credit_ctrl #(
    parameter int N_PROD      = 8,
    parameter int SEL_W       = 3,
    parameter int VAL_W       = 5,
    parameter int TIMEOUT_CYC = 16,
    parameter logic [N_PROD*VAL_W-1:0] PRICES =
        {5'd12, 5'd10, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd2}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin_valid,
    input  logic [VAL_W-1:0] coin_value,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] product_sel,
    output logic [VAL_W-1:0] credit_total,
    output logic             release_product,
    output logic             refund,
    output logic [VAL_W-1:0] refund_value,
    output logic             coin_reject,
    output logic             busy
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, COLLECT, CHECK, VEND, REFUND
    } state_t;

    state_t           state, state_nx;
    logic [VAL_W-1:0] credit, credit_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic [SEL_W-1:0] sel_q, sel_nx;
    logic [VAL_W-1:0] change_q, change_nx;
    logic [VAL_W-1:0] amt;
    logic             reject_nx;
    logic [VAL_W:0]   sum;
    logic [VAL_W-1:0] price;

    logic             release_nx, refund_nx, busy_nx;
    logic [VAL_W-1:0] refval_nx;

    // Out-of-range indices read as price 0, which forces a full refund.
    function automatic logic [VAL_W-1:0] price_of(input logic [SEL_W-1:0] s);
        logic [VAL_W-1:0] p;
        p = '0;
        for (int i = 0; i < N_PROD; i++)
            if (s == SEL_W'(i))
                p = PRICES[i*VAL_W +: VAL_W];
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            credit          <= '0;
            timer           <= '0;
            sel_q           <= '0;
            change_q        <= '0;
            release_product <= 1'b0;
            refund          <= 1'b0;
            refund_value    <= '0;
            coin_reject     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_nx;
            credit          <= credit_nx;
            timer           <= timer_nx;
            sel_q           <= sel_nx;
            change_q        <= change_nx;
            release_product <= release_nx;
            refund          <= refund_nx;
            refund_value    <= refval_nx;
            coin_reject     <= reject_nx;
            busy            <= busy_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        credit_nx = credit;
        timer_nx  = timer;
        sel_nx    = sel_q;
        change_nx = change_q;
        amt       = '0;
        reject_nx = 1'b0;
        sum       = {1'b0, credit} + {1'b0, coin_value};
        price     = price_of(sel_q);
        unique case (state)
            IDLE: begin
                if (coin_valid) begin
                    if (coin_value != '0) begin
                        credit_nx = coin_value;
                        timer_nx  = '0;
                        state_nx  = COLLECT;
                    end else begin
                        reject_nx = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (sel_valid) begin
                    sel_nx    = product_sel;
                    state_nx  = CHECK;
                    reject_nx = coin_valid;
                end else if (coin_valid) begin
                    timer_nx = '0;
                    if (sum[VAL_W])
                        reject_nx = 1'b1;
                    else
                        credit_nx = sum[VAL_W-1:0];
                end else if (timer == TLAST) begin
                    amt       = credit;
                    credit_nx = '0;
                    state_nx  = REFUND;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            CHECK: begin
                reject_nx = coin_valid;
                credit_nx = '0;
                timer_nx  = '0;
                change_nx = '0;
                amt       = credit;
                state_nx  = REFUND;
`ifdef VEND_CHANGE_EN
                if (price != '0 && credit >= price) begin
                    change_nx = credit - price;
                    amt       = '0;
                    state_nx  = VEND;
                end
`else
                if (price != '0 && credit == price) begin
                    amt      = '0;
                    state_nx = VEND;
                end
`endif
            end
            VEND: begin
                reject_nx = coin_valid;
                credit_nx = '0;
                if (change_q != '0) begin
                    amt      = change_q;
                    state_nx = REFUND;
                end else begin
                    state_nx = IDLE;
                end
            end
            REFUND: begin
                reject_nx = coin_valid;
                credit_nx = '0;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        release_nx = (state_nx == VEND);
        refund_nx  = (state_nx == REFUND);
        refval_nx  = refund_nx ? amt : '0;
        busy_nx    = (state_nx == CHECK) || (state_nx == VEND)
                  || (state_nx == REFUND);
    end

    assign credit_total = credit;

endmodule

// File: tb/tb_vending_credit_ctrl.sv
// Bench for vending_credit_ctrl: directed plan steps then random traffic,
// checked every cycle against a per-cycle expectation timeline.
module tb_vending_credit_ctrl;

    localparam int N_PROD  = 6;
    localparam int SEL_W   = 3;
    localparam int VAL_W   = 5;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 4096;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             coin_valid = 1'b0;
    logic [VAL_W-1:0] coin_value = '0;
    logic             sel_valid = 1'b0;
    logic [SEL_W-1:0] product_sel = '0;
    logic [VAL_W-1:0] credit_total;
    logic             release_product;
    logic             refund;
    logic [VAL_W-1:0] refund_value;
    logic             coin_reject;
    logic             busy;

    vending_credit_ctrl #(
        .N_PROD(N_PROD), .SEL_W(SEL_W), .VAL_W(VAL_W),
        .TIMEOUT_CYC(TIMEOUT),
        .PRICES({5'd0, 5'd7, 5'd6, 5'd5, 5'd4, 5'd2})
    ) dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .product_sel(product_sel),
        .credit_total(credit_total),
        .release_product(release_product),
        .refund(refund), .refund_value(refund_value),
        .coin_reject(coin_reject), .busy(busy)
    );

    always #5 clk = ~clk;

    int prices[N_PROD] = '{2, 4, 5, 6, 7, 0};

    // Expected outputs after each clock edge, indexed by edge number.
    bit       e_rel [DEPTH];
    bit       e_ref [DEPTH];
    bit       e_rej [DEPTH];
    bit       e_busy[DEPTH];
    bit [4:0] e_rv  [DEPTH];
    bit [4:0] e_cred[DEPTH];

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  m_credit = 0;
    int  m_idle = 0;
    bit  m_coll = 0;
`ifdef VEND_CHANGE_EN
    bit  chg_en = 1'b1;
`else
    bit  chg_en = 1'b0;
`endif

    task automatic model(input bit cv, input int v, input bit sv,
                         input int ps, input bit rs);
        int e;
        int p;
        bit ok;
        e = cyc;
        if (rs) begin
            for (int k = 0; k < 4; k++) begin
                e_rel[e+k] = 0; e_ref[e+k] = 0; e_rej[e+k] = 0;
                e_busy[e+k] = 0; e_rv[e+k] = 0; e_cred[e+k] = 0;
            end
            m_credit = 0; m_idle = 0; m_coll = 0;
        end else if (e > 0 && e_busy[e-1]) begin
            if (cv) e_rej[e] = 1;
            e_cred[e] = 5'(m_credit);
        end else if (!m_coll) begin
            if (cv) begin
                if (v != 0) begin
                    m_credit = v; m_coll = 1; m_idle = 0;
                end else begin
                    e_rej[e] = 1;
                end
            end
            e_cred[e] = 5'(m_credit);
        end else if (sv) begin
            if (cv) e_rej[e] = 1;
            p = (ps < N_PROD) ? prices[ps] : 0;
            ok = (p != 0) && (chg_en ? (m_credit >= p) : (m_credit == p));
            e_cred[e] = 5'(m_credit);
            e_busy[e] = 1;
            e_busy[e+1] = 1;
            if (ok) begin
                e_rel[e+1] = 1;
                if (m_credit > p) begin
                    e_busy[e+2] = 1;
                    e_ref[e+2] = 1;
                    e_rv[e+2] = 5'(m_credit - p);
                end
            end else begin
                e_ref[e+1] = 1;
                e_rv[e+1] = 5'(m_credit);
            end
            m_credit = 0; m_coll = 0;
        end else if (cv) begin
            m_idle = 0;
            if (m_credit + v > 31) e_rej[e] = 1;
            else m_credit = m_credit + v;
            e_cred[e] = 5'(m_credit);
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                e_ref[e] = 1;
                e_rv[e] = 5'(m_credit);
                e_busy[e] = 1;
                m_credit = 0; m_coll = 0;
            end
            e_cred[e] = 5'(m_credit);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit cv, input int v, input bit sv,
                        input int ps, input bit rs);
        coin_valid  = cv;
        coin_value  = 5'(v);
        sel_valid   = sv;
        product_sel = 3'(ps);
        reset       = rs;
        @(posedge clk);
        model(cv, v, sv, ps, rs);
        #1;
        chk("release", {7'd0, release_product}, {7'd0, e_rel[cyc]});
        chk("refund", {7'd0, refund}, {7'd0, e_ref[cyc]});
        chk("refund_value", {3'd0, refund_value}, {3'd0, e_rv[cyc]});
        chk("coin_reject", {7'd0, coin_reject}, {7'd0, e_rej[cyc]});
        chk("busy", {7'd0, busy}, {7'd0, e_busy[cyc]});
        chk("credit", {3'd0, credit_total}, {3'd0, e_cred[cyc]});
        cyc++;
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic coin(input int v);
        step(1, v, 0, 0, 0);
    endtask

    task automatic sel(input int ps);
        step(0, 0, 1, ps, 0);
    endtask

    initial begin
        int pc;
        int psel;
        int v;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        idle(2);
        step(1, 0, 0, 0, 0);
        sel(1);
        idle(2);
        coin(2); coin(2); sel(1); idle(4);
        coin(5); coin(2); sel(2); idle(4);
        coin(3); idle(18);
        coin(20); coin(10); coin(5); coin(1); sel(3); idle(4);
        coin(4); step(1, 2, 1, 1, 0); idle(4);
        coin(6); sel(7); idle(4);
        coin(6); sel(5); idle(4);
        coin(6); step(0, 0, 0, 0, 1); idle(3);
        coin(3); idle(2); sel(1); coin(1); coin(1); idle(4);
        pc = 20;
        psel = 10;
        for (int i = 0; i < 2400; i++) begin
            if (i % 64 == 0) begin
                pc   = int'($urandom_range(0, 40));
                psel = int'($urandom_range(2, 15));
            end
            v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                            : int'($urandom_range(0, 8));
            step($urandom_range(0, 99) < pc, v,
                 $urandom_range(0, 99) < psel,
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 399) == 0);
        end
        idle(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vending_credit_ctrl.md
Name: vending_credit_ctrl

Overview:
- Clocked, parametrised successor of the vending machine's product/coin comparator.
- Accumulates inserted coin value into a credit register and holds a per-product price table for N_PROD products.
- On product selection, compares credit against price and either releases the product or refunds the coins. Also refunds automatically after an inactivity timeout.
- Sits between the coin acceptor front-end and the dispenser/refund actuators.

Parameters:
- N_PROD, 8, number of selectable products (≥2).
- SEL_W, 3, width of product_sel; must satisfy 2^SEL_W ≥ N_PROD.
- VAL_W, 5, width of coin value, credit, price and change.
- TIMEOUT_CYC, 16, idle cycles in COLLECT before automatic refund (≥2).
- PRICES, {12,10,8,7,6,5,4,2}, packed N_PROD*VAL_W vector. Price of product i = PRICES[i*VAL_W +: VAL_W]. Default: product0=2, 1=4, 2=5, 3=6, 4=7, 5=8, 6=10, 7=12.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- coin_valid  in  1  one-cycle strobe: coin inserted.
- coin_value  in  VAL_W  value of inserted coin, sampled when coin_valid=1.
- sel_valid  in  1  one-cycle strobe: product selected.
- product_sel  in  SEL_W  product index, sampled when sel_valid=1.
- credit_total  out  VAL_W  current accumulated credit (registered).
- release_product  out  1  one-cycle pulse: dispense product.
- refund  out  1  one-cycle pulse: return coins/change.
- refund_value  out  VAL_W  amount to return; valid while refund=1, else 0.
- coin_reject  out  1  one-cycle pulse: coin not accepted, returned physically.
- busy  out  1  high in CHECK, VEND, REFUND.

Behaviour:
- Reset: state=IDLE, credit_total=0, timer=0. release_product, refund, coin_reject, busy = 0; refund_value=0. Reset mid-transaction discards credit with no refund pulse.
- States: IDLE, COLLECT, CHECK, VEND, REFUND.
- IDLE:
  - coin_valid with coin_value≠0 → credit=coin_value, go COLLECT.
  - coin_value=0 → coin_reject.
  - sel_valid ignored (no pulse).
- COLLECT, coin handling:
  - coin_valid and credit+coin_value ≤ 2^VAL_W−1 → add to credit, timer=0.
  - Sum would overflow → coin_reject pulse next cycle; credit unchanged; timer still cleared.
- COLLECT, selection:
  - sel_valid → latch product_sel, go CHECK.
  - A coin in the same cycle as sel_valid is rejected (coin_reject); selection wins.
- COLLECT, timeout:
  - Otherwise timer increments.
  - Timer reaching TIMEOUT_CYC−1 → go REFUND with refund_value=credit.
- CHECK (one cycle):
  - product index ≥ N_PROD, or price=0 → REFUND with full credit.
  - Otherwise apply compare rule (see Optional Feature) → VEND or REFUND.
- VEND (one cycle): release_product=1; credit cleared.
  - If change>0, go REFUND with refund_value=change. Else go IDLE.
- REFUND (one cycle): refund=1, refund_value driven, credit cleared, go IDLE.
- Latency: sel_valid at cycle N → CHECK at N+1 → release_product or refund at N+2. Change refund, if any, at N+3.
- Busy window: coins arriving while busy=1 get coin_reject and are not added. sel_valid while busy is ignored.
- All outputs registered; no combinational input→output paths.

Optional Feature:
- Macro: VEND_CHANGE_EN.
- Defined: vend when credit ≥ price; change = credit − price is refunded the cycle after release_product.
- Undefined: vend only when credit == price (change always 0). Any mismatch → full refund, no release_product.

Test Plan:
1. Coins 2 then 2, select product1 (price 4) → release_product at sel+2, refund never asserted, credit_total returns to 0, state IDLE.
2. Coins 5+2=7, select product2 (price 5):
   - VEND_CHANGE_EN undefined → refund=1 with refund_value=7 at sel+2, no release.
   - VEND_CHANGE_EN defined → release at sel+2, then refund_value=2 at sel+3.
3. Coin 3, then no activity for 16 cycles → refund=1 with refund_value=3 on timeout, credit_total=0.
4. Coins 20+10=30, then coin 5 → coin_reject pulse, credit_total stays 30. Coin 1 → credit 31 accepted.
5. Coin 4, then sel_valid=1 and coin_valid=1 (value 2) in the same cycle, product1 → coin_reject pulse, release_product at sel+2, credit 4 consumed.
6. Coin 6, select product_sel=7 with N_PROD=6 → refund_value=6.
   - Separately: coin 6 then reset asserted one cycle → credit 0, no refund pulse, IDLE.
